// File: rtl/riscv_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_e : controller state encoding (RUN, MD_BUSY; 2 and 3 reserved)
//   REG_X0     : architectural zero register, never a hazard source
//   MD_CNT_W   : width of the MUL/DIV occupancy counter (covers latency up to 16)
package riscv_hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1
    } hz_state_e;

    localparam logic [4:0] REG_X0   = 5'd0;
    localparam int         MD_CNT_W = $clog2(16);

endpackage

// File: rtl/riscv_muldiv_timer.sv
// Loadable down-counter timing MUL/DIV occupancy of EX.
// Ports:
//   clk, rst  : core clock, synchronous active-high reset (clears count)
//   load      : load load_val this cycle (takes priority over decrement)
//   load_val  : number of further stalled cycles after the start cycle
//   zero      : count is zero
//   busy      : count is non-zero
module riscv_muldiv_timer
    import riscv_hazard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    output logic                zero,
    output logic                busy
);

    logic [MD_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);
    assign busy = !zero;

endmodule

// File: rtl/riscv_hazard_controller.sv
// Pipeline hazard sequencing: load-use stall, multi-cycle MUL/DIV hold of EX,
// and redirect flush. Outputs are combinational from registered state plus
// current inputs; all outputs are forced low while rst is high.
// Ports:
//   clk, rst                         : core clock, synchronous active-high reset
//   id_rs1/rs2_addr, id_rs1/rs2_used : source operands of the ID instruction
//   ex_rd_addr, ex_wr_en, ex_is_load : destination info of the EX instruction
//   ex_muldiv_start                  : pulse, MUL/DIV entered EX
//   ex_redirect                      : taken branch/jump resolved in EX
//   stall_if/id/ex                   : hold PC / IF-ID / ID-EX
//   flush_id, flush_ex, bubble_mem   : squash IF-ID / bubble into ID-EX / EX-MEM
//   muldiv_done                      : pulse, MUL/DIV result valid
//   hz_state                         : current state for debug
// Optional feature (macro RISCV_HAZARD_PERF_CNT_EN): saturating counters
//   perf_load_stalls, perf_md_stalls, perf_flushes, each CNT_W bits.
module riscv_hazard_controller
    import riscv_hazard_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_wr_en,
    input  logic       ex_is_load,
    input  logic       ex_muldiv_start,
    input  logic       ex_redirect,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       flush_id,
    output logic       flush_ex,
    output logic       bubble_mem,
    output logic       muldiv_done,
    output logic [1:0] hz_state
`ifdef RISCV_HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_load_stalls,
    output logic [CNT_W-1:0] perf_md_stalls,
    output logic [CNT_W-1:0] perf_flushes
`endif
);

    if (MULDIV_LAT < 2 || MULDIV_LAT > 16 || CNT_W < 1) begin : g_param_check
        $error("riscv_hazard_controller: MULDIV_LAT must be 2..16 and CNT_W >= 1");
    end

    // The start cycle itself is stalled, so the timer covers the remaining
    // MULDIV_LAT-2 stalled cycles; the release cycle happens at count zero.
    localparam logic [MD_CNT_W-1:0] MD_LOAD_VAL = MD_CNT_W'(MULDIV_LAT - 2);

    hz_state_e state_q, state_d;
    logic      load_use;
    logic      md_load, md_zero, md_busy;

    assign load_use = ex_is_load && ex_wr_en && (ex_rd_addr != REG_X0) &&
                      ((id_rs1_used && (ex_rd_addr == id_rs1_addr)) ||
                       (id_rs2_used && (ex_rd_addr == id_rs2_addr)));

    riscv_muldiv_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (md_load),
        .load_val (MD_LOAD_VAL),
        .zero     (md_zero),
        .busy     (md_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        md_load     = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        bubble_mem  = 1'b0;
        muldiv_done = 1'b0;
        if (!rst) begin
            case (state_q)
                MD_BUSY: begin
                    if (md_busy) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                    end else if (md_zero) begin
                        muldiv_done = 1'b1;
                        state_d     = RUN;
                    end
                end
                // RUN and the reserved encodings behave identically.
                default: begin
                    state_d = RUN;
                    if (ex_redirect) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (ex_muldiv_start) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        md_load    = 1'b1;
                        state_d    = MD_BUSY;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
            endcase
        end
    end

    assign hz_state = rst ? 2'd0 : state_q;

`ifdef RISCV_HAZARD_PERF_CNT_EN
    // A load-use stall is the only case that holds IF without holding EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_stalls <= '0;
            perf_md_stalls   <= '0;
            perf_flushes     <= '0;
        end else begin
            if (stall_if && !stall_ex && (perf_load_stalls != '1))
                perf_load_stalls <= perf_load_stalls + 1'b1;
            if (stall_ex && (perf_md_stalls != '1))
                perf_md_stalls <= perf_md_stalls + 1'b1;
            if (flush_id && (perf_flushes != '1))
                perf_flushes <= perf_flushes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_hazard_controller.sv
// Self-checking bench: two controllers (MULDIV_LAT 4 and 2) share randomized
// stimulus and are compared every cycle against a cycle-budget model, after a
// set of directed sequences with literal expectations.
module tb_riscv_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_rs1_used, id_rs2_used, ex_wr_en, ex_is_load;
    logic       ex_muldiv_start, ex_redirect;

    logic       stall_if_v[2], stall_id_v[2], stall_ex_v[2];
    logic       flush_id_v[2], flush_ex_v[2], bubble_mem_v[2], muldiv_done_v[2];
    logic [1:0] hz_v[2];
`ifdef RISCV_HAZARD_PERF_CNT_EN
    logic [31:0] perf_ld_v[2], perf_md_v[2], perf_fl_v[2];
`endif

    int checks   = 0;
    int failures = 0;
    int md_left[2];   // cycles EX remains occupied by MUL/DIV after the current one

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        riscv_hazard_controller #(.MULDIV_LAT(g == 0 ? 4 : 2)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .id_rs1_addr     (id_rs1_addr),
            .id_rs2_addr     (id_rs2_addr),
            .id_rs1_used     (id_rs1_used),
            .id_rs2_used     (id_rs2_used),
            .ex_rd_addr      (ex_rd_addr),
            .ex_wr_en        (ex_wr_en),
            .ex_is_load      (ex_is_load),
            .ex_muldiv_start (ex_muldiv_start),
            .ex_redirect     (ex_redirect),
            .stall_if        (stall_if_v[g]),
            .stall_id        (stall_id_v[g]),
            .stall_ex        (stall_ex_v[g]),
            .flush_id        (flush_id_v[g]),
            .flush_ex        (flush_ex_v[g]),
            .bubble_mem      (bubble_mem_v[g]),
            .muldiv_done     (muldiv_done_v[g]),
            .hz_state        (hz_v[g])
`ifdef RISCV_HAZARD_PERF_CNT_EN
            ,
            .perf_load_stalls(perf_ld_v[g]),
            .perf_md_stalls  (perf_md_v[g]),
            .perf_flushes    (perf_fl_v[g])
`endif
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, muldiv_done}
    function automatic logic [6:0] outs(input int i);
        return {stall_if_v[i], stall_id_v[i], stall_ex_v[i], flush_id_v[i],
                flush_ex_v[i], bubble_mem_v[i], muldiv_done_v[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model, evaluated mid-cycle when inputs are stable.
    always @(negedge clk) begin : model_cmp
        logic       lu;
        logic [6:0] e;
        logic [1:0] eh;
        assert (!(ex_muldiv_start && ex_is_load))
            else $error("illegal: muldiv start together with load");
        lu = ex_is_load && ex_wr_en && (ex_rd_addr != 5'd0) &&
             ((id_rs1_used && ex_rd_addr == id_rs1_addr) ||
              (id_rs2_used && ex_rd_addr == id_rs2_addr));
        for (int i = 0; i < 2; i++) begin
            e  = '0;
            eh = 2'd0;
            if (rst) begin
                md_left[i] = 0;
            end else if (md_left[i] > 0) begin
                assert (!ex_redirect && !ex_muldiv_start)
                    else $error("illegal: redirect/start while MUL/DIV busy");
                eh = 2'd1;
                e  = (md_left[i] > 1) ? 7'b1110010 : 7'b0000001;
                md_left[i]--;
            end else if (ex_redirect) begin
                e = 7'b0001100;
            end else if (ex_muldiv_start) begin
                e = 7'b1110010;
                md_left[i] = lat_of(i) - 1;
            end else if (lu) begin
                e = 7'b1100100;
            end
            chk($sformatf("outs_dut%0d", i), 32'(outs(i)), 32'(e));
            chk($sformatf("hz_dut%0d", i), 32'(hz_v[i]), 32'(eh));
        end
    end

    task automatic drive(input logic r, input logic ld, input logic wr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic start, input logic redir);
        @(posedge clk);
        #1;
        rst = r; ex_is_load = ld; ex_wr_en = wr; ex_rd_addr = rd;
        id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_muldiv_start = start; ex_redirect = redir;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    endtask

    initial begin
        md_left[0] = 0; md_left[1] = 0;
        rst = 1'b1; ex_is_load = 0; ex_wr_en = 0; ex_rd_addr = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_muldiv_start = 0; ex_redirect = 0;

        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        drive(1, 1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0);
        chk("rst_outs", 32'(outs(0)), 32'h0);
        chk("rst_hz", 32'(hz_v[0]), 32'h0);

        drive(0, 1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0);
        chk("load_use", 32'(outs(0)), 32'(7'b1100100));
        idle();
        chk("load_use_clear", 32'(outs(0)), 32'h0);

        drive(0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        chk("load_x0", 32'(outs(0)), 32'h0);

        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        chk("md_T", 32'(outs(0)), 32'(7'b1110010));
        chk("md_T_hz", 32'(hz_v[0]), 32'h0);
        chk("md2_T", 32'(outs(1)), 32'(7'b1110010));
        idle();
        chk("md_T1", 32'(outs(0)), 32'(7'b1110010));
        chk("md_T1_hz", 32'(hz_v[0]), 32'h1);
        chk("md2_T1_done", 32'(outs(1)), 32'(7'b0000001));
        idle();
        chk("md_T2", 32'(outs(0)), 32'(7'b1110010));
        chk("md2_T2", 32'(outs(1)), 32'h0);
        idle();
        chk("md_T3_done", 32'(outs(0)), 32'(7'b0000001));
        idle();
        chk("md_T4", 32'(outs(0)), 32'h0);
        chk("md_T4_hz", 32'(hz_v[0]), 32'h0);

        drive(0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1);
        chk("redirect_lu", 32'(outs(0)), 32'(7'b0001100));

        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        chk("rst_mid_outs", 32'(outs(0)), 32'h0);
        chk("rst_mid_hz", 32'(hz_v[0]), 32'h0);
        idle();
        chk("post_rst_hz", 32'(hz_v[0]), 32'h0);
        chk("post_rst_outs", 32'(outs(0)), 32'h0);
        idle();
        chk("post_rst_no_done", 32'(outs(0)), 32'h0);

`ifdef RISCV_HAZARD_PERF_CNT_EN
        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        idle();
        chk("perf_clr", perf_ld_v[0] | perf_md_v[0] | perf_fl_v[0], 32'h0);
        repeat (3) drive(0, 1, 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0);
        idle();
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        repeat (4) idle();
        chk("perf_load_stalls", perf_ld_v[0], 32'd3);
        chk("perf_md_stalls", perf_md_v[0], 32'd3);
        chk("perf_md_stalls_lat2", perf_md_v[1], 32'd1);
        chk("perf_flushes", perf_fl_v[0], 32'd0);
`endif

        repeat (3000) begin : rand_loop
            logic busy, r, ld, start, redir;
            busy  = (md_left[0] > 0) || (md_left[1] > 0);
            r     = ($urandom_range(0, 99) < 3);
            redir = !busy && ($urandom_range(0, 99) < 10);
            start = !busy && ($urandom_range(0, 99) < 12);
            ld    = !start && ($urandom_range(0, 99) < 50);
            drive(r, ld, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), start, redir);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_hazard_controller.md
Name: riscv_hazard_controller

Overview:
- Pipeline sequencing controller that pairs with the EX-stage operand forwarding unit.
- Covers the hazards that forwarding cannot resolve:
  - load-use dependencies, by stalling IF/ID and inserting a bubble into EX;
  - multi-cycle MUL/DIV occupancy of EX, via an FSM and counter;
  - control redirects, by flushing ID/EX.
- Sits between the ID/EX pipeline registers and the fetch/decode stall logic.

Parameters:
- MULDIV_LAT, 4: total cycles a MUL/DIV op occupies EX. Legal range 2..16; elaboration error outside it.
- CNT_W, 32: width of the performance counters. Used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs1_addr  in  5  rs1 of instruction in ID
- id_rs2_addr  in  5  rs2 of instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_rd_addr  in  5  rd of instruction in EX
- ex_wr_en  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_muldiv_start  in  1  one-cycle pulse: MUL/DIV entered EX
- ex_redirect  in  1  branch/jump taken, resolved in EX
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- stall_ex  out  1  hold ID/EX register
- flush_id  out  1  squash IF/ID contents
- flush_ex  out  1  load bubble into ID/EX
- bubble_mem  out  1  load bubble into EX/MEM
- muldiv_done  out  1  one-cycle pulse: MUL/DIV result valid, EX releases
- hz_state  out  2  current FSM state, for debug

Behaviour:
- Reset: state=RUN, counter=0.
- While rst is high, every output is forced to 0, including the cycle reset is sampled. Reset mid-MUL/DIV abandons the op with no muldiv_done.
- Outputs are combinational from registered state plus current inputs (0-cycle latency). State and counter are registered.
- States:
  - RUN=2'd0
  - MD_BUSY=2'd1
  - 2'd2 and 2'd3 are reserved; treat as RUN.
- load_use = ex_is_load & ex_wr_en & (ex_rd_addr!=0) & ((id_rs1_used & ex_rd_addr==id_rs1_addr) | (id_rs2_used & ex_rd_addr==id_rs2_addr)).
- Priority in RUN: ex_redirect > ex_muldiv_start > load_use.
  - ex_redirect: flush_id=1 and flush_ex=1 for that cycle; no stalls. A concurrent load_use is ignored.
  - ex_muldiv_start: stall_if=stall_id=stall_ex=1 and bubble_mem=1. counter<=MULDIV_LAT-2. Next state MD_BUSY.
  - load_use only: stall_if=stall_id=1 and flush_ex=1 for exactly that cycle. The load advances to MEM, so the condition self-clears.
- MD_BUSY:
  - While counter!=0: stall_if, stall_id, stall_ex and bubble_mem are asserted; counter decrements.
  - When counter==0: all stalls deassert, muldiv_done=1, next state RUN.
  - Net effect: the op spans MULDIV_LAT cycles in EX with MULDIV_LAT-1 stalled cycles.
  - With MULDIV_LAT=2, MD_BUSY lasts exactly one release cycle.
- Inputs ignored in MD_BUSY:
  - ex_redirect, ex_muldiv_start and load_use are ignored; EX holds the MUL/DIV, so they cannot legally assert.
  - The bench asserts that ex_redirect and ex_muldiv_start stay 0 while in MD_BUSY.
- x0 is never a hazard source. A load with rd=0 never stalls.
- ex_muldiv_start and ex_is_load asserted together is illegal (mutually exclusive opcodes); assertion.

Optional Feature:
- Macro: RISCV_HAZARD_PERF_CNT_EN.
- When defined, adds three outputs, each CNT_W bits and saturating at all-ones:
  - perf_load_stalls: increments on each load_use stall cycle.
  - perf_md_stalls: increments on each MUL/DIV stalled cycle.
  - perf_flushes: increments on each redirect cycle.
  - All three clear on rst.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_hazard_pkg:
  - hz_state_e enum (RUN, MD_BUSY);
  - REG_X0 = 5'd0;
  - MD_CNT_W = $clog2(16).
- Sub-module riscv_muldiv_timer: a loadable down-counter with a zero flag. Inputs: clk, rst, load, load_val. Outputs: zero, busy.

Test Plan:
- Load-use:
  - Stimulus: ex_is_load=1, ex_wr_en=1, ex_rd_addr=5, id_rs2_addr=5, id_rs2_used=1.
  - Response: stall_if=stall_id=flush_ex=1 for 1 cycle; deasserts once ex_is_load drops.
- Load to x0:
  - Stimulus: same as load-use but ex_rd_addr=0=id_rs1_addr.
  - Response: no stall, no flush.
- MUL/DIV, default latency:
  - Stimulus: MULDIV_LAT=4, ex_muldiv_start pulse at cycle T.
  - Response: stall_ex=1 in T..T+2; muldiv_done=1 and stall_ex=0 at T+3; hz_state=RUN at T+4.
- Redirect plus load-use:
  - Stimulus: ex_redirect=1 in the same cycle as a load_use match.
  - Response: flush_id=flush_ex=1, stall_if=0.
- Reset mid-op:
  - Stimulus: rst=1 at T+1 of a MULDIV_LAT=4 op.
  - Response: all outputs 0 that cycle; hz_state=RUN afterwards; no muldiv_done.
- Performance counters:
  - Stimulus: RISCV_HAZARD_PERF_CNT_EN defined; 3 load-use stalls and 1 MULDIV_LAT=4 op.
  - Response: perf_load_stalls=3, perf_md_stalls=3.
